// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - md_op encodings (md_op_e)
//   - FSM state encoding (state_e); the DIV state exists only when
//     MDU_DIV_EN is defined
//   - default busy-cycle counts for multiply and divide
//   - small helper for sizing the busy counter
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1
`ifdef MDU_DIV_EN
    ,
    ST_DIV  = 2'd2
`endif
  } state_e;

  localparam int unsigned MULT_CYC_DEF = 5;
  localparam int unsigned DIV_CYC_DEF  = 10;

  function automatic int unsigned max_u(input int unsigned x, input int unsigned y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: EX-stage <-> multiply/divide unit signal bundle.
//   master (pipeline side): drives start, md_op, rd_sel, a, b, cancel;
//                           receives busy, mdm_rd
//   slave  (mdu_ctrl):      the reverse
interface mdu_if;
  logic        start;
  logic [2:0]  md_op;
  logic        rd_sel;
  logic [31:0] a;
  logic [31:0] b;
  logic        cancel;
  logic        busy;
  logic [31:0] mdm_rd;

  modport master (
    output start, md_op, rd_sel, a, b, cancel,
    input  busy, mdm_rd
  );

  modport slave (
    input  start, md_op, rd_sel, a, b, cancel,
    output busy, mdm_rd
  );
endinterface

// File: rtl/mdu_divider.sv
// mdu_divider: combinational 32-bit signed/unsigned divider.
//   dividend, divisor : operands
//   is_signed         : 1 = two's-complement divide, 0 = unsigned
//   quot, rem         : quotient (toward zero) / remainder (dividend's sign)
//   div_zero          : divisor is zero; quot/rem are forced to 0
module mdu_divider (
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        is_signed,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  // Divide magnitudes, then restore signs. 0x80000000 / -1 falls out
  // naturally: magnitude 0x80000000 negates back to itself, remainder 0.
  always_comb begin
    neg_a    = is_signed & dividend[31];
    neg_b    = is_signed & divisor[31];
    mag_a    = neg_a ? -dividend : dividend;
    mag_b    = neg_b ? -divisor  : divisor;
    div_zero = (divisor == '0);
    q_mag    = '0;
    r_mag    = '0;
    if (!div_zero) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
    end
    quot = (neg_a ^ neg_b) ? -q_mag : q_mag;
    rem  = neg_a ? -r_mag : r_mag;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle HI/LO multiply/divide unit controller.
//   clk    : sole clock, rising edge
//   reset  : synchronous, active-high
//   bus    : mdu_if.slave (start, md_op, rd_sel, a, b, cancel -> busy, mdm_rd)
// Parameters MULT_CYC / DIV_CYC set the busy length of each operation.
// Compile-time option: define MDU_DIV_EN to enable div/divu; otherwise those
// codes are no-ops and the divider is not built.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYC = MULT_CYC_DEF,
  parameter int unsigned DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  localparam int unsigned CNT_MAX = max_u(MULT_CYC, DIV_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        phi_q, phi_d;
  logic [31:0]        plo_q, plo_d;

  logic               accept;
  logic               is_mul;
  logic               done;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;

`ifdef MDU_DIV_EN
  logic               is_div;
  logic               div_signed;
  logic [31:0]        div_quot;
  logic [31:0]        div_rem;
  logic               div_zero;

  mdu_divider u_div (
    .dividend (bus.a),
    .divisor  (bus.b),
    .is_signed(div_signed),
    .quot     (div_quot),
    .rem      (div_rem),
    .div_zero (div_zero)
  );
`endif

  always_comb begin : decode
    accept = bus.start && !bus.cancel && (state_q == ST_IDLE);
    is_mul = (bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU);
`ifdef MDU_DIV_EN
    is_div     = (bus.md_op == MD_DIV) || (bus.md_op == MD_DIVU);
    div_signed = (bus.md_op == MD_DIV);
`endif
    done = (state_q != ST_IDLE) && (cnt_q == CNT_W'(1));
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin : next_state
    state_d = state_q;
    if (accept && is_mul)
      state_d = ST_MUL;
`ifdef MDU_DIV_EN
    else if (accept && is_div)
      state_d = ST_DIV;
`endif
    else if (done)
      state_d = ST_IDLE;
  end

  // FSM: outputs
  always_comb begin : outputs
    bus.busy   = (state_q != ST_IDLE);
    bus.mdm_rd = bus.rd_sel ? hi_q : lo_q;
  end

  // Datapath: operands are captured only at the accept edge into the
  // pending registers; HI/LO change only on commit or mthi/mtlo.
  always_comb begin : datapath
    prod_s = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    prod_u = {32'b0, bus.a} * {32'b0, bus.b};
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    phi_d  = phi_q;
    plo_d  = plo_q;
    if (accept) begin
      if (is_mul) begin
        {phi_d, plo_d} = (bus.md_op == MD_MULT) ? prod_s : prod_u;
        cnt_d          = CNT_W'(MULT_CYC);
      end
`ifdef MDU_DIV_EN
      else if (is_div) begin
        // Zero divisor: pending mirrors current HI/LO, so the commit is a no-op.
        phi_d = div_zero ? hi_q : div_rem;
        plo_d = div_zero ? lo_q : div_quot;
        cnt_d = CNT_W'(DIV_CYC);
      end
`endif
      else if (bus.md_op == MD_MTHI) begin
        hi_d = bus.a;
      end
      else if (bus.md_op == MD_MTLO) begin
        lo_d = bus.a;
      end
    end
    else if (state_q != ST_IDLE) begin
      cnt_d = cnt_q - CNT_W'(1);
      if (done) begin
        hi_d = phi_q;
        lo_d = plo_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
    end
  end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed + randomized bench for mdu_ctrl against a
// transaction-level HI/LO model (plain longint arithmetic, countdown of
// remaining busy cycles). Honours MDU_DIV_EN for the div/divu checks.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bif ();

  mdu_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  // reference model
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_wr;
  int          m_left;
  bit          m_valid = 1'b0;

  int n_pass    = 0;
  int n_checks  = 0;
  int busy_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic void model_edge(input bit rst, input bit st, input logic [2:0] op,
                                     input logic [31:0] av, input logic [31:0] bv,
                                     input bit can);
    longint          sa, sb, q, r;
    longint unsigned pu;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (rst) begin
      m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0;
      m_left = 0; m_wr = 1'b0; m_valid = 1'b1;
      return;
    end
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_wr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (st && !can) begin
      case (op)
        MD_MULT: begin
          q = sa * sb;
          m_phi = q[63:32]; m_plo = q[31:0];
          m_wr = 1'b1; m_left = MC;
        end
        MD_MULTU: begin
          pu = longint'(av) * longint'(bv);
          m_phi = pu[63:32]; m_plo = pu[31:0];
          m_wr = 1'b1; m_left = MC;
        end
`ifdef MDU_DIV_EN
        MD_DIV, MD_DIVU: begin
          m_wr = (bv != 0);
          if (bv != 0) begin
            if (op == MD_DIV) begin
              q = sa / sb; r = sa % sb;
              m_plo = q[31:0]; m_phi = r[31:0];
            end else begin
              m_plo = av / bv; m_phi = av % bv;
            end
          end
          m_left = DC;
        end
`endif
        MD_MTHI: m_hi = av;
        MD_MTLO: m_lo = av;
        default: ;
      endcase
    end
  endfunction

  // One clock cycle: drive inputs, check outputs mid-cycle, advance model.
  task automatic cyc(input bit st, input logic [2:0] op, input bit rs,
                     input logic [31:0] av, input logic [31:0] bv,
                     input bit can, input bit rst);
    bif.start = st; bif.md_op = op; bif.rd_sel = rs;
    bif.a = av; bif.b = bv; bif.cancel = can; reset = rst;
    #2;
    if (bif.busy) busy_seen++;
    if (m_valid) begin
      check("busy", 32'(bif.busy), 32'(m_left > 0));
      check("mdm_rd", bif.mdm_rd, rs ? m_hi : m_lo);
    end
    @(posedge clk);
    model_edge(rst, st, op, av, bv, can);
    #1;
  endtask

  task automatic idle(input int n, input bit rs);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'($urandom_range(0, 7)), rs, $urandom, $urandom, 1'b0, 1'b0);
  endtask

  task automatic expect_rd(input string tag, input bit sel, input logic [31:0] val);
    bif.rd_sel = sel;
    #1;
    check(tag, bif.mdm_rd, val);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3, 4:    return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(posedge clk); #1;
    cyc(1'b1, MD_MULT, 1'b0, 32'd1, 32'd1, 1'b0, 1'b1);  // reset beats start
    cyc(1'b0, MD_MULT, 1'b0, '0, '0, 1'b0, 1'b1);
    expect_rd("reset_hi", 1'b1, 32'h0);
    check("reset_busy", 32'(bif.busy), 32'h0);

    // mult -2 * 3
    busy_seen = 0;
    cyc(1'b1, MD_MULT, 1'b0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    idle(8, 1'b0);
    check("mult_busy_len", busy_seen, MC);
    expect_rd("mult_hi", 1'b1, 32'hFFFF_FFFF);
    expect_rd("mult_lo", 1'b0, 32'hFFFF_FFFA);

    // mthi, read next cycle
    busy_seen = 0;
    cyc(1'b1, MD_MTHI, 1'b0, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, MD_MULT, 1'b1, '0, '0, 1'b0, 1'b0);
    expect_rd("mthi_hi", 1'b1, 32'h1234_5678);
    expect_rd("mthi_lo_kept", 1'b0, 32'hFFFF_FFFA);
    check("mthi_no_busy", busy_seen, 0);

    // cancelled start
    busy_seen = 0;
    cyc(1'b1, MD_MULT, 1'b0, 32'd9, 32'd9, 1'b1, 1'b0);
    idle(3, 1'b1);
    check("cancel_no_busy", busy_seen, 0);
    expect_rd("cancel_hi", 1'b1, 32'h1234_5678);

    // start during busy ignored; cancel mid-op ignored; operands changing ignored
    cyc(1'b1, MD_MULTU, 1'b0, 32'd7, 32'd6, 1'b0, 1'b0);
    cyc(1'b1, MD_MULT, 1'b0, 32'd100, 32'd100, 1'b0, 1'b0);
    cyc(1'b1, MD_MTHI, 1'b0, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    idle(6, 1'b0);
    expect_rd("busy_start_lo", 1'b0, 32'd42);
    expect_rd("busy_start_hi", 1'b1, 32'h0);

    // reset mid-mult: no late commit
    cyc(1'b1, MD_MTLO, 1'b0, 32'd77, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, MD_MULT, 1'b0, 32'd3, 32'd3, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, MD_MULT, 1'b0, '0, '0, 1'b0, 1'b1);
    check("rst_mul_busy", 32'(bif.busy), 32'h0);
    idle(8, 1'b0);
    expect_rd("rst_mul_lo", 1'b0, 32'h0);

`ifdef MDU_DIV_EN
    busy_seen = 0;
    cyc(1'b1, MD_DIVU, 1'b0, 32'd7, 32'd2, 1'b0, 1'b0);
    idle(12, 1'b0);
    check("divu_busy_len", busy_seen, DC);
    expect_rd("divu_lo", 1'b0, 32'd3);
    expect_rd("divu_hi", 1'b1, 32'd1);

    cyc(1'b1, MD_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle(11, 1'b0);
    expect_rd("div_lo", 1'b0, 32'hFFFF_FFFD);
    expect_rd("div_hi", 1'b1, 32'hFFFF_FFFF);

    cyc(1'b1, MD_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    idle(11, 1'b0);
    expect_rd("ovf_lo", 1'b0, 32'h8000_0000);
    expect_rd("ovf_hi", 1'b1, 32'h0);

    cyc(1'b1, MD_MTHI, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, MD_MTLO, 1'b0, 32'd6, 32'd0, 1'b0, 1'b0);
    busy_seen = 0;
    cyc(1'b1, MD_DIV, 1'b0, 32'd100, 32'd0, 1'b0, 1'b0);
    idle(12, 1'b0);
    check("div0_busy_len", busy_seen, DC);
    expect_rd("div0_hi", 1'b1, 32'd5);
    expect_rd("div0_lo", 1'b0, 32'd6);

    cyc(1'b1, MD_DIVU, 1'b0, 32'd50, 32'd7, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, MD_MULT, 1'b0, '0, '0, 1'b0, 1'b1);
    check("rst_div_busy", 32'(bif.busy), 32'h0);
    idle(12, 1'b1);
    expect_rd("rst_div_hi", 1'b1, 32'h0);
    expect_rd("rst_div_lo", 1'b0, 32'h0);
`else
    cyc(1'b1, MD_MTHI, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0);
    cyc(1'b1, MD_MTLO, 1'b0, 32'd6, 32'd0, 1'b0, 1'b0);
    busy_seen = 0;
    cyc(1'b1, MD_DIVU, 1'b0, 32'd7, 32'd2, 1'b0, 1'b0);
    idle(12, 1'b0);
    check("nodiv_busy", busy_seen, 0);
    expect_rd("nodiv_hi", 1'b1, 32'd5);
    expect_rd("nodiv_lo", 1'b0, 32'd6);
`endif

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), 1'($urandom),
          pick_val(), pick_val(), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 99) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYC, default 5: busy cycles after a mult/multu start.
REQ-002 Parameter DIV_CYC, default 10: busy cycles after a div/divu start.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  EX-stage multiply/divide-class instruction valid this cycle.
REQ-006 md_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op.
REQ-007 rd_sel  input  1  mfhi/mflo source select: 0 LO, 1 HI.
REQ-008 a  input  32  operand A (rs, forwarded).
REQ-009 b  input  32  operand B (rt, forwarded).
REQ-010 cancel  input  1  interrupt/exception request in the same cycle; kills the start.
REQ-011 busy  output  1  operation in progress; hazard unit stalls any MD-class instruction while high.
REQ-012 mdm_rd  output  32  HI when rd_sel=1, else LO; combinational read of the committed registers.

Function
REQ-013 FSM states: IDLE, MUL, DIV; busy SHALL be 1 exactly when the state is not IDLE.
REQ-014 Accepted start: start=1, cancel=0, state IDLE; any other start SHALL be ignored with no state change.
REQ-015 Accepted mult/multu: 64-bit signed/unsigned product latched into pending regs; state to MUL; counter loaded MULT_CYC.
REQ-016 Accepted div/divu: signed/unsigned quotient to pending LO, remainder to pending HI; state to DIV; counter loaded DIV_CYC.
REQ-017 Signed division SHALL truncate toward zero; remainder SHALL take the dividend's sign.
REQ-018 0x80000000 / 0xFFFFFFFF signed SHALL give LO=0x80000000, HI=0.
REQ-019 Divisor 0: full DIV_CYC busy sequence SHALL run, and HI/LO SHALL remain unchanged at commit.
REQ-020 The counter SHALL decrement once per busy cycle.
REQ-021 On the edge where the counter goes 1->0: pending regs commit to HI/LO, state returns to IDLE.
REQ-022 busy SHALL be high for exactly MULT_CYC or DIV_CYC cycles, starting the cycle after the accept edge.
REQ-023 New HI/LO SHALL be visible on mdm_rd in the first cycle busy=0.
REQ-024 Accepted mthi/mtlo: a written to HI/LO at the next edge; no busy; the other register is unchanged.
REQ-025 cancel SHALL have no effect once an operation is in progress; an accepted operation always completes.
REQ-026 Operands SHALL be sampled only at the accept edge; later changes to a/b SHALL be ignored.
REQ-027 The pending regs SHALL not be observable on mdm_rd before commit.

Reset
REQ-028 While reset=1: state IDLE, counter 0, HI/LO/pending all 0; busy=0 and mdm_rd=0 from the next cycle.
REQ-029 Reset mid-operation SHALL abandon the operation with no commit, and overrides a simultaneous start.

Configuration
REQ-030 Macro MDU_DIV_EN defined: div/divu behave per REQ-016..019.
REQ-031 Macro MDU_DIV_EN undefined: div/divu codes are no-ops (no busy, HI/LO unchanged); the DIV state and divider logic are compiled out.

Structure
REQ-032 Shared package mdu_pkg: md_op encodings, FSM state encoding, MULT_CYC/DIV_CYC defaults.
REQ-033 One sub-module, mdu_divider (combinational signed/unsigned quotient/remainder), instantiated only under MDU_DIV_EN.

Verification
REQ-034 mult a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-035 divu a=7, b=2 -> busy high 10 cycles; then LO=3, HI=1. div a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-036 mthi a=0x12345678, then rd_sel=1 the next cycle -> mdm_rd=0x12345678, busy never asserted, LO unchanged.
REQ-037 start mult with cancel=1 -> busy stays 0, HI/LO unchanged. start during busy -> ignored, first result commits intact.
REQ-038 reset asserted in cycle 3 of a div -> busy=0 the next cycle, HI=LO=0, no late commit.
REQ-039 div by 0 after HI=5, LO=6 -> busy 10 cycles, HI=5, LO=6. Without MDU_DIV_EN: divu 7/2 -> busy=0, HI/LO unchanged.
